rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter BASE_ADDRESS, default 24'd0: value that addr[31:8] must match for an in-range access.
REQ-002 clk  input  1: single clock; all state updates on its rising edge.
REQ-003 reset  input  1: asynchronous, active-high reset.
REQ-004 req0 / req1  input  1 each: read request from port 0 (instruction fetch) and port 1 (data/debug).
REQ-005 addr0 / addr1  input  32 each: byte address for the matching port, stable while that port's req is high.
REQ-006 gnt0 / gnt1  output  1 each: registered one-cycle pulse, request accepted.
REQ-007 rdata0 / rdata1  output  32 each: registered read data for the matching port.
REQ-008 rvalid0 / rvalid1  output  1 each: registered one-cycle pulse, rdata and err valid.
REQ-009 err0 / err1  output  1 each: registered; access was unaligned or out of range.
REQ-010 rom_addr  output  32: registered address driven to the shared combinational 32-bit ROM.
REQ-011 rom_data  input  32: ROM read data, combinational from rom_addr.
REQ-012 busy  output  1: high whenever state is not IDLE.

Function
REQ-013 FSM states: IDLE, READ; reset state IDLE.
REQ-014 IDLE, neither req high -> remain IDLE; no outputs pulse.
REQ-015 IDLE, one or both req high -> select one winner (REQ-018), latch its addr into rom_addr and its port id, pulse its gnt next cycle, go to READ.
REQ-016 READ -> capture rom_data into the winner's rdata, pulse the winner's rvalid next cycle, return to IDLE.
REQ-017 Timing: req sampled at end of cycle N -> gnt high in N+1 -> rvalid high in N+2; maximum throughput one access per 2 cycles.
REQ-018 Arbitration: a single request always wins; simultaneous requests alternate by round-robin, the port not granted last winning.
REQ-019 last_grant register updates only on a grant; resets to port 1, so port 0 wins the first tie.
REQ-020 Requester protocol: deassert or change req in the cycle after seeing gnt; a req still high in IDLE after rvalid counts as a new request.
REQ-021 Request sampling: req is ignored while in READ; no queuing of requests.
REQ-022 Error condition: addr[1:0]!=0 or addr[31:8]!=BASE_ADDRESS -> err=1, rdata=32'h0 with rvalid; the ROM is still addressed.
REQ-023 Non-winning port outputs: rdata and err hold their last values; gnt and rvalid stay 0.
REQ-024 Outputs are never combinational from req or addr inputs.

Reset
REQ-025 Reset asserted at any time -> within the same cycle: state=IDLE, gnt*=0, rvalid*=0, err*=0, rdata*=0, rom_addr=0, busy=0, last_grant=1.
REQ-026 Reset during READ -> the pending access is dropped; no rvalid after reset releases.
REQ-027 First arbitration occurs in the first clock edge after reset deasserts.

Configuration
REQ-028 Macro ROM_ARB_FIXED_PRIO_EN defined -> port 0 wins every tie and last_grant is unused.
REQ-029 Macro ROM_ARB_FIXED_PRIO_EN undefined -> round-robin per REQ-018/019.

Verification
REQ-030 ROM word 0 = 32'h8C020004; req0=1, addr0=0 single -> gnt0 at N+1; rvalid0 at N+2 with rdata0=32'h8C020004, err0=0.
REQ-031 Round-robin build, both req held high with addr0=4, addr1=8 -> grants 0,1,0,1 on alternating accesses; rdata0=32'h00421020, rdata1=32'h08000007.
REQ-032 Fixed-priority build, same stimulus as REQ-031 -> port 0 granted every access; gnt1 never asserted.
REQ-033 addr1=32'h00000006, then addr1=32'h00000100 -> both: rvalid1=1, err1=1, rdata1=0.
REQ-034 Assert reset in READ cycle -> no rvalid; busy=0 immediately; next req0 is serviced normally with latency 2.
REQ-035 req0 raised while in READ servicing port 1 -> req0 granted at the next IDLE; no request lost or duplicated.

Source files
------------

// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of a shared combinational ROM: one access every two cycles.
// Define ROM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default is round-robin.
module rom_arbiter #(
    parameter logic [23:0] BASE_ADDRESS = 24'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        grant_go;
    logic        read_done;
    logic        win_port;
    logic        cur_port;
    logic        access_err;
    logic [31:0] read_word;

`ifndef ROM_ARB_FIXED_PRIO_EN
    logic        last_grant;
`endif

    // Winner selection; only meaningful when grant_go is high.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        win_port = 1'b0;
        if (req0 && req1) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
            win_port = 1'b0;
`else
            win_port = ~last_grant;
`endif
        end else if (req1) begin
            win_port = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        grant_go   = 1'b0;
        read_done  = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant_go   = 1'b1;
                    state_next = READ;
                end
            end
            READ: begin
                read_done  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The ROM is addressed even for a bad access; only the returned word is squashed.
    assign access_err = (rom_addr[1:0] != 2'b00) || (rom_addr[31:8] != BASE_ADDRESS);
    assign read_word  = access_err ? 32'h0 : rom_data;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rdata0   <= 32'h0;
            rdata1   <= 32'h0;
            err0     <= 1'b0;
            err1     <= 1'b0;
            rom_addr <= 32'h0;
            cur_port <= 1'b0;
        end else begin
            gnt0    <= grant_go && !win_port;
            gnt1    <= grant_go && win_port;
            rvalid0 <= read_done && !cur_port;
            rvalid1 <= read_done && cur_port;
            if (grant_go) begin
                rom_addr <= win_port ? addr1 : addr0;
                cur_port <= win_port;
            end
            // Non-winning port keeps its previous rdata/err.
            if (read_done) begin
                if (cur_port) begin
                    rdata1 <= read_word;
                    err1   <= access_err;
                end else begin
                    rdata0 <= read_word;
                    err0   <= access_err;
                end
            end
        end
    end

`ifndef ROM_ARB_FIXED_PRIO_EN
    // Resets to port 1 so that port 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (grant_go) begin
            last_grant <= win_port;
        end
    end
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed vector table, corner sequences,
// then random traffic against a transaction-level timeline model.
module tb_rom_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1;
    logic [31:0] addr0, addr1;
    logic        gnt0, gnt1;
    logic [31:0] rdata0, rdata1;
    logic        rvalid0, rvalid1;
    logic        err0, err1;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        req0;
        logic        req1;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic        gnt0;
        logic        gnt1;
        logic        rv0;
        logic        rv1;
        logic        busy;
        logic [31:0] rdata0;
        logic [31:0] rdata1;
        logic        err0;
        logic        err1;
    } vec_t;

    rom_arbiter #(.BASE_ADDRESS(24'd0)) dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .req1     (req1),
        .addr0    (addr0),
        .addr1    (addr1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .err0     (err0),
        .err1     (err1),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .busy     (busy)
    );

    // Combinational ROM: three known words, hashed filler elsewhere.
    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h8C020004;
            32'h4:   return 32'h00421020;
            32'h8:   return 32'h08000007;
            default: return (a * 32'h9E3779B1) ^ 32'h5A5A5A5B;
        endcase
    endfunction

    assign rom_data = rom_fn(rom_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, ".gnt0"},    32'(gnt0),    32'(v.gnt0));
        check({tag, ".gnt1"},    32'(gnt1),    32'(v.gnt1));
        check({tag, ".rvalid0"}, 32'(rvalid0), 32'(v.rv0));
        check({tag, ".rvalid1"}, 32'(rvalid1), 32'(v.rv1));
        check({tag, ".busy"},    32'(busy),    32'(v.busy));
        check({tag, ".rdata0"},  rdata0,       v.rdata0);
        check({tag, ".rdata1"},  rdata1,       v.rdata1);
        check({tag, ".err0"},    32'(err0),    32'(v.err0));
        check({tag, ".err1"},    32'(err1),    32'(v.err1));
    endtask

    function automatic vec_t quiet(input logic [31:0] rd0, input logic [31:0] rd1,
                                   input logic e0, input logic e1);
        vec_t v;
        v = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rd0, rd1, e0, e1};
        return v;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 7))
            0:       a = {24'd0, 8'($urandom_range(0, 255))} | 32'h1;
            1:       a = $urandom | 32'h100;
            default: a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        endcase
        return a;
    endfunction

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:8] != 24'd0);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; addr0 = 32'h0; addr1 = 32'h0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    vec_t vecs[9];
    vec_t v;

    // Random-phase model: edge-indexed timeline of grants and returns.
    int          free_at;
    logic        last_p;
    logic [31:0] m_rdata[2];
    logic        m_err[2];
    logic        rv_pending;
    logic        rv_port;
    logic [31:0] rv_data;
    logic        rv_err;

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; addr0 = 32'h0; addr1 = 32'h0;
        #12;
        check_all("reset", quiet(32'h0, 32'h0, 1'b0, 1'b0));
        check("reset.rom_addr", rom_addr, 32'h0);

        // Single port 0 read, error cases on port 1, normal port 1 read.
        vecs[0] = '{1'b1, 1'b0, 32'h0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 32'h0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8C020004, 32'h0,        1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 32'h0, 32'h6,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8C020004, 32'h0,        1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h0, 32'h6,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8C020004, 32'h0,        1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 32'h0, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8C020004, 32'h0,        1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 32'h0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8C020004, 32'h0,        1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 32'h0, 32'h8,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8C020004, 32'h0,        1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 32'h0, 32'h8,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8C020004, 32'h08000007, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 32'h0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8C020004, 32'h08000007, 1'b0, 1'b0};

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            req0 = vecs[i].req0; req1 = vecs[i].req1;
            addr0 = vecs[i].addr0; addr1 = vecs[i].addr1;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Tie with both requests held: round-robin alternates, fixed priority always port 0.
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1; addr0 = 32'h4; addr1 = 32'h8;
        v = quiet(32'h8C020004, 32'h08000007, 1'b0, 1'b0);
        for (int a = 0; a < 4; a++) begin
            logic p;
`ifdef ROM_ARB_FIXED_PRIO_EN
            p = 1'b0;
`else
            p = (a % 2) == 1;
`endif
            @(posedge clk);
            #1;
            v.gnt0 = !p; v.gnt1 = p; v.rv0 = 1'b0; v.rv1 = 1'b0; v.busy = 1'b1;
            check_all($sformatf("tie_gnt%0d", a), v);
            @(posedge clk);
            #1;
            v.gnt0 = 1'b0; v.gnt1 = 1'b0; v.rv0 = !p; v.rv1 = p; v.busy = 1'b0;
            if (p) v.rdata1 = 32'h08000007; else v.rdata0 = 32'h00421020;
            check_all($sformatf("tie_rv%0d", a), v);
        end
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk);
        #1;
        check_all("tie_idle", quiet(v.rdata0, v.rdata1, 1'b0, 1'b0));

        // Reset while in READ: access dropped, everything cleared at once.
        @(negedge clk);
        req0 = 1'b1; addr0 = 32'h0;
        @(posedge clk);
        #1;
        v = quiet(v.rdata0, v.rdata1, 1'b0, 1'b0);
        v.gnt0 = 1'b1; v.busy = 1'b1;
        check_all("rst_read_gnt", v);
        #2;
        reset = 1'b1;
        #1;
        check_all("rst_read_now", quiet(32'h0, 32'h0, 1'b0, 1'b0));
        check("rst_read.rom_addr", rom_addr, 32'h0);
        req0 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_all($sformatf("rst_read_quiet%0d", i), quiet(32'h0, 32'h0, 1'b0, 1'b0));
        end
        @(negedge clk);
        req0 = 1'b1; addr0 = 32'h0;
        @(posedge clk);
        #1;
        v = quiet(32'h0, 32'h0, 1'b0, 1'b0);
        v.gnt0 = 1'b1; v.busy = 1'b1;
        check_all("after_rst_gnt", v);
        @(negedge clk);
        req0 = 1'b0;
        @(posedge clk);
        #1;
        v = quiet(32'h8C020004, 32'h0, 1'b0, 1'b0);
        v.rv0 = 1'b1;
        check_all("after_rst_rv", v);

        // req0 raised while port 1 is being read: served once at the next IDLE.
        @(negedge clk);
        req1 = 1'b1; addr1 = 32'h4;
        @(posedge clk);
        #1;
        v = quiet(32'h8C020004, 32'h0, 1'b0, 1'b0);
        v.gnt1 = 1'b1; v.busy = 1'b1;
        check_all("late_gnt1", v);
        @(negedge clk);
        req1 = 1'b0; req0 = 1'b1; addr0 = 32'h8;
        @(posedge clk);
        #1;
        v = quiet(32'h8C020004, 32'h00421020, 1'b0, 1'b0);
        v.rv1 = 1'b1;
        check_all("late_rv1", v);
        @(posedge clk);
        #1;
        v = quiet(32'h8C020004, 32'h00421020, 1'b0, 1'b0);
        v.gnt0 = 1'b1; v.busy = 1'b1;
        check_all("late_gnt0", v);
        @(negedge clk);
        req0 = 1'b0;
        @(posedge clk);
        #1;
        v = quiet(32'h08000007, 32'h00421020, 1'b0, 1'b0);
        v.rv0 = 1'b1;
        check_all("late_rv0", v);
        @(posedge clk);
        #1;
        check_all("late_idle", quiet(32'h08000007, 32'h00421020, 1'b0, 1'b0));

        // Random traffic against the timeline model.
        do_reset();
        free_at = 0;
        last_p = 1'b1;
        m_rdata[0] = 32'h0; m_rdata[1] = 32'h0;
        m_err[0] = 1'b0; m_err[1] = 1'b0;
        rv_pending = 1'b0; rv_port = 1'b0; rv_data = 32'h0; rv_err = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            logic        p;
            logic [31:0] a;
            @(negedge clk);
            req0 = ($urandom_range(0, 99) < 55);
            req1 = ($urandom_range(0, 99) < 55);
            addr0 = rand_addr();
            addr1 = rand_addr();
            v = quiet(32'h0, 32'h0, 1'b0, 1'b0);
            if (rv_pending) begin
                if (rv_port) v.rv1 = 1'b1; else v.rv0 = 1'b1;
                m_rdata[rv_port] = rv_data;
                m_err[rv_port] = rv_err;
                rv_pending = 1'b0;
            end
            if (k >= free_at && (req0 || req1)) begin
                if (req0 && req1) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
                    p = 1'b0;
`else
                    p = (last_p == 1'b1) ? 1'b0 : 1'b1;
`endif
                end else begin
                    p = req1;
                end
                a = p ? addr1 : addr0;
                if (p) v.gnt1 = 1'b1; else v.gnt0 = 1'b1;
                v.busy = 1'b1;
                rv_pending = 1'b1;
                rv_port = p;
                rv_err = addr_bad(a);
                rv_data = rv_err ? 32'h0 : rom_fn(a);
                last_p = p;
                free_at = k + 2;
            end
            v.rdata0 = m_rdata[0]; v.rdata1 = m_rdata[1];
            v.err0 = m_err[0]; v.err1 = m_err[1];
            @(posedge clk);
            #1;
            check_all($sformatf("rand%0d", k), v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
